fp_scoreboard: RTL and testbench
================================

# fp_scoreboard

Issue controller for the floating-point side of the 5-stage RISC-V core: it tracks pending writes to the 32 FP registers and stalls IF/ID on FP read-after-write, write-after-write and structural hazards. It also sequences the iterative FP divide/sqrt unit and arbitrates the single FP register-file write port between the pipelined FP unit (PRE-EX-NORMAL) and the divider. It sits beside the integer hazard unit in ID; its `fp_stall` is ORed into the IF/ID hold.

## Interface
- `SCALE`, 5, register-address width; 2^SCALE FP registers.
- `DIV_LAT`, 12, divider iteration cycles, minimum 2.
- `MAX_INFLIGHT`, 4, maximum pipelined FP ops in flight, minimum 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_float` in 1: the ID instruction is an FP op.
- `id_div` in 1: the FP op is fdiv/fsqrt (iterative unit); always writes an FP register.
- `id_fwe` in 1: the FP op writes an FP register.
- `id_fdes`, `id_fsrc1`, `id_fsrc2` in SCALE: FP destination and sources.
- `id_fuse1`, `id_fuse2` in 1: the corresponding source is read.
- `ex_stall` in 1: external stall from the integer hazard unit; blocks issue.
- `flush` in 1: branch flush; kills the ID instruction.
- `pipe_wb_valid` in 1: a pipelined FP op completes in NORMAL (one pulse per op).
- `pipe_wb_fwe` in 1: that completion writes the FP register file.
- `pipe_wb_addr` in SCALE: its destination.
- `fp_stall` out 1: hold IF/ID.
- `fp_issue` out 1: the ID FP instruction advances this cycle.
- `div_start` out 1: start pulse to the divider datapath.
- `div_wb_valid` out 1: the divider owns the FP write port this cycle.
- `div_wb_addr` out SCALE: the divider destination.
- `busy` out 2^SCALE: pending-write vector.
- `inflight` out clog2(MAX_INFLIGHT+1): count of pipelined ops in flight.

## Operation
- f0 is an ordinary register. There is no zero-register exemption.
- `done_clr[r]` is the completion-clear term for register r. It is true when `pipe_wb_valid & pipe_wb_fwe` and `pipe_wb_addr==r`, or when `div_wb_valid` and `div_wb_addr==r`.
- `eff_busy[r]` is the effective busy bit: `busy[r] & ~done_clr[r]` when FP_FWD_EN is defined, otherwise `busy[r]`.
- Hazard terms:
  - raw = (`id_fuse1` & eff_busy[src1]) | (`id_fuse2` & eff_busy[src2]).
  - waw = `id_fwe` & eff_busy[fdes].
  - struct = `id_div` ? (div state != IDLE) : (`inflight`==MAX_INFLIGHT & ~`pipe_wb_valid`).
- Control outputs:
  - `fp_stall` = `id_valid` & `id_float` & ~`flush` & (raw|waw|struct).
  - `fp_issue` = `id_valid` & `id_float` & ~`flush` & ~`ex_stall` & ~`fp_stall`.
  - `div_start` = `fp_issue` & `id_div`.
- `busy` update per edge: clear on `done_clr`, then set `id_fdes` on `fp_issue` & (`id_fwe`|`id_div`). When set and clear hit the same address in the same cycle, set wins.
- `inflight` update: +1 on `fp_issue` & ~`id_div`, -1 on `pipe_wb_valid`; both in one cycle leaves it unchanged. Overflow cannot occur because of struct. An underflowing `pipe_wb_valid` is ignored.
- Divider FSM:
  - IDLE: on `div_start`, latch `id_fdes`, load cnt=DIV_LAT-1, go to RUN.
  - RUN: decrement cnt; at cnt==0 go to WB.
  - WB: `div_wb_valid` = ~(`pipe_wb_valid` & `pipe_wb_fwe`). The pipelined unit has write priority. On a granted write go to IDLE, otherwise stay in WB.
- `flush` suppresses issue only. In-flight pipelined ops and a running divide complete normally.

## Timing
- `fp_stall`, `fp_issue`, `div_start` and `div_wb_valid` are combinational from state and inputs. All state is registered.
- Reset (async, mid-operation included): `busy`=0, `inflight`=0, FSM=IDLE, cnt=0, `div_wb_addr`=0. All outputs are 0. A running divide is abandoned.
- Divide issued in cycle t: RUN spans t+1..t+DIV_LAT. The earliest `div_wb_valid` is t+DIV_LAT+1. Each cycle of conflict delays it by one cycle.
- The busy bit is visible from the cycle after issue.
- With FP_FWD_EN, a dependent instruction issues in the completion cycle. Without it, it issues one cycle later.
- The next divide can issue at the earliest in the cycle after the divider write.

## Configuration
- `FP_FWD_EN` defined: completion bypass. A register whose write completes this cycle is not a hazard, which assumes a write-first FP register file. A full `inflight` with a simultaneous completion also admits issue.
- `FP_FWD_EN` undefined: hazards use the registered `busy` only, and struct ignores `pipe_wb_valid`. Each dependency costs one extra stall cycle.

## Test plan
- Reset mid-divide: issue fdiv f3, then pulse `rst_n` low at RUN cnt=5 -> `busy`=0, `div_wb_valid` never asserts, FSM in IDLE.
- RAW: issue fadd f1 with `pipe_wb_valid` at t+3, then ID fmul reads f1 -> `fp_stall`=1 in t+1..t+2; `fp_issue` at t+3 (t+4 without FP_FWD_EN).
- Divider latency with DIV_LAT=12: fdiv f5 issued at t=10 -> `div_start`=1 at 10, `div_wb_valid`=1 with addr 5 at 23, `busy[5]` cleared at 24.
- Write-port conflict: divider in WB while `pipe_wb_valid`=`pipe_wb_fwe`=1 for 2 cycles -> `div_wb_valid` low for those 2 cycles, then high for 1 cycle.
- Structural with MAX_INFLIGHT=4: 4 fadds with no completions -> 5th stalls. A second fdiv during RUN stalls until FSM is IDLE.
- Flush/external stall: `flush`=1 with hazard-free fadd -> `fp_issue`=0, `fp_stall`=0, `busy` unchanged. `ex_stall`=1 -> `fp_issue`=0.

Source files
------------

// File: rtl/fp_scoreboard.sv
// FP issue controller: busy-bit hazards, in-flight limit, divide sequencer and FP write-port arbitration.
// Define FP_FWD_EN to let a completing write bypass its busy bit and a full in-flight count.
module fp_scoreboard #(
    parameter int SCALE        = 5,
    parameter int DIV_LAT      = 12,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              id_valid,
    input  logic                              id_float,
    input  logic                              id_div,
    input  logic                              id_fwe,
    input  logic [SCALE-1:0]                  id_fdes,
    input  logic [SCALE-1:0]                  id_fsrc1,
    input  logic [SCALE-1:0]                  id_fsrc2,
    input  logic                              id_fuse1,
    input  logic                              id_fuse2,
    input  logic                              ex_stall,
    input  logic                              flush,
    input  logic                              pipe_wb_valid,
    input  logic                              pipe_wb_fwe,
    input  logic [SCALE-1:0]                  pipe_wb_addr,
    output logic                              fp_stall,
    output logic                              fp_issue,
    output logic                              div_start,
    output logic                              div_wb_valid,
    output logic [SCALE-1:0]                  div_wb_addr,
    output logic [(1<<SCALE)-1:0]             busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [1:0]                        divStateDbg
);
    localparam int NREG = 1 << SCALE;
    localparam int CNTW = $clog2(DIV_LAT);
    localparam int IFW  = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2} divState_t;

    divState_t       divState;
    logic [CNTW-1:0] divCnt;

    logic            pipeWrite;
    logic            rawHaz;
    logic            wawHaz;
    logic            structHaz;
    logic            inflightFull;
    logic            inflightInc;
    logic            inflightDec;
    logic [NREG-1:0] doneClr;
    logic [NREG-1:0] effBusy;
    logic [NREG-1:0] busySet;

    // The pipelined unit always wins the shared write port; the divider waits in WB.
    assign pipeWrite    = pipe_wb_valid & pipe_wb_fwe;
    assign div_wb_valid = (divState == WB) & ~pipeWrite;

    assign doneClr = (pipeWrite    ? (NREG'(1) << pipe_wb_addr) : '0)
                   | (div_wb_valid ? (NREG'(1) << div_wb_addr)  : '0);

`ifdef FP_FWD_EN
    assign effBusy      = busy & ~doneClr;
    assign inflightFull = (inflight == IFW'(MAX_INFLIGHT)) & ~pipe_wb_valid;
`else
    assign effBusy      = busy;
    assign inflightFull = (inflight == IFW'(MAX_INFLIGHT));
`endif

    assign rawHaz    = (id_fuse1 & effBusy[id_fsrc1]) | (id_fuse2 & effBusy[id_fsrc2]);
    assign wawHaz    = id_fwe & effBusy[id_fdes];
    assign structHaz = id_div ? (divState != IDLE) : inflightFull;

    // Issue handshake: ID offers an op with id_valid & id_float; fp_issue is the
    // accept in the same cycle, and nothing is recorded unless fp_issue is high.
    assign fp_stall  = id_valid & id_float & ~flush & (rawHaz | wawHaz | structHaz);
    assign fp_issue  = id_valid & id_float & ~flush & ~ex_stall & ~fp_stall;
    assign div_start = fp_issue & id_div;

    assign busySet     = (fp_issue & (id_fwe | id_div)) ? (NREG'(1) << id_fdes) : '0;
    assign inflightInc = fp_issue & ~id_div;
    assign inflightDec = pipe_wb_valid & (inflight != '0);

    assign divStateDbg = divState;

    // Set is applied after clear so a same-cycle reissue of a completing register stays busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            inflight <= '0;
        end else begin
            busy <= (busy & ~doneClr) | busySet;
            case ({inflightInc, inflightDec})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divState    <= IDLE;
            divCnt      <= '0;
            div_wb_addr <= '0;
        end else begin
            case (divState)
                IDLE: begin
                    if (div_start) begin
                        div_wb_addr <= id_fdes;
                        divCnt      <= CNTW'(DIV_LAT - 1);
                        divState    <= RUN;
                    end
                end
                RUN: begin
                    if (divCnt == '0) divState <= WB;
                    else              divCnt   <= divCnt - CNTW'(1);
                end
                WB: begin
                    if (div_wb_valid) divState <= IDLE;
                end
                default: divState <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_scoreboard.sv
// Bench for fp_scoreboard: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_fp_scoreboard;
    localparam int SCALE        = 5;
    localparam int DIV_LAT      = 12;
    localparam int MAX_INFLIGHT = 4;
    localparam int NREG         = 1 << SCALE;
    localparam int IFW          = $clog2(MAX_INFLIGHT + 1);
`ifdef FP_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid, id_float, id_div, id_fwe;
    logic [SCALE-1:0] id_fdes, id_fsrc1, id_fsrc2;
    logic             id_fuse1, id_fuse2, ex_stall, flush;
    logic             pipe_wb_valid, pipe_wb_fwe;
    logic [SCALE-1:0] pipe_wb_addr;
    logic             fp_stall, fp_issue, div_start, div_wb_valid;
    logic [SCALE-1:0] div_wb_addr;
    logic [NREG-1:0]  busy;
    logic [IFW-1:0]   inflight;
    logic [1:0]       divStateDbg;

    // Clock / reset
    always #5 clk = ~clk;

    fp_scoreboard #(.SCALE(SCALE), .DIV_LAT(DIV_LAT), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_float(id_float), .id_div(id_div), .id_fwe(id_fwe),
        .id_fdes(id_fdes), .id_fsrc1(id_fsrc1), .id_fsrc2(id_fsrc2),
        .id_fuse1(id_fuse1), .id_fuse2(id_fuse2), .ex_stall(ex_stall), .flush(flush),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_fwe(pipe_wb_fwe), .pipe_wb_addr(pipe_wb_addr),
        .fp_stall(fp_stall), .fp_issue(fp_issue), .div_start(div_start),
        .div_wb_valid(div_wb_valid), .div_wb_addr(div_wb_addr),
        .busy(busy), .inflight(inflight), .divStateDbg(divStateDbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending-write set, queue of pipelined ops awaiting completion, divide timestamp
    logic [NREG-1:0]  mBusy;
    logic [SCALE:0]   exp_q[$];
    bit               mDivActive;
    int               mDivIssue;
    logic [SCALE-1:0] mDivAddr;
    bit               expStall, expIssue, expStart, expDivWb;

    function automatic void model_reset();
        mBusy      = '0;
        exp_q.delete();
        mDivActive = 1'b0;
        mDivIssue  = 0;
        mDivAddr   = '0;
    endfunction

    function automatic void predict();
        logic [NREG-1:0] clr;
        logic [NREG-1:0] eff;
        bit raw, waw, st;
        clr      = '0;
        expDivWb = mDivActive && (cyc >= mDivIssue + DIV_LAT + 1) && !(pipe_wb_valid && pipe_wb_fwe);
        if (pipe_wb_valid && pipe_wb_fwe) clr[pipe_wb_addr] = 1'b1;
        if (expDivWb) clr[mDivAddr] = 1'b1;
        eff = (FWD != 0) ? (mBusy & ~clr) : mBusy;
        raw = (id_fuse1 && eff[id_fsrc1]) || (id_fuse2 && eff[id_fsrc2]);
        waw = id_fwe && eff[id_fdes];
        if (id_div) st = mDivActive;
        else        st = (exp_q.size() == MAX_INFLIGHT) && !((FWD != 0) && pipe_wb_valid);
        expStall = id_valid && id_float && !flush && (raw || waw || st);
        expIssue = id_valid && id_float && !flush && !ex_stall && !expStall;
        expStart = expIssue && id_div;
    endfunction

    // One clock: predict from current inputs, advance the model on the edge, return #1 after it
    task automatic tick();
        logic [NREG-1:0] clr;
        predict();
        @(posedge clk);
        clr = '0;
        if (pipe_wb_valid && pipe_wb_fwe) clr[pipe_wb_addr] = 1'b1;
        if (expDivWb) clr[mDivAddr] = 1'b1;
        mBusy = mBusy & ~clr;
        if (expIssue && (id_fwe || id_div)) mBusy[id_fdes] = 1'b1;
        if (pipe_wb_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        if (expIssue && !id_div) exp_q.push_back({id_fwe, id_fdes});
        if (expDivWb) mDivActive = 1'b0;
        if (expStart) begin
            mDivActive = 1'b1;
            mDivIssue  = cyc;
            mDivAddr   = id_fdes;
        end
        cyc++;
        #1;
    endtask

    // Driver tasks
    task automatic clear_id();
        id_valid = 1'b0; id_float = 1'b0; id_div = 1'b0; id_fwe = 1'b0;
        id_fdes = '0; id_fsrc1 = '0; id_fsrc2 = '0; id_fuse1 = 1'b0; id_fuse2 = 1'b0;
        ex_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic present_op(input bit isDiv, input int des, input bit use1, input int src1);
        id_valid = 1'b1; id_float = 1'b1; id_div = isDiv; id_fwe = 1'b1;
        id_fdes  = SCALE'(des); id_fuse1 = use1; id_fsrc1 = SCALE'(src1);
        id_fuse2 = 1'b0; id_fsrc2 = '0;
    endtask

    task automatic drive_pipe(input bit v);
        if (v && exp_q.size() > 0) begin
            pipe_wb_valid = 1'b1;
            {pipe_wb_fwe, pipe_wb_addr} = exp_q[0];
        end else begin
            pipe_wb_valid = 1'b0; pipe_wb_fwe = 1'b0; pipe_wb_addr = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        clear_id();
        while ((exp_q.size() > 0 || mDivActive) && n < 200) begin
            drive_pipe(exp_q.size() > 0);
            tick();
            n++;
        end
        drive_pipe(1'b0);
        @(negedge clk);
        checks += 2;
        if (busy !== '0) begin errors++; $display("FAIL drain_busy got=%h exp=0", busy); end
        if (inflight !== '0) begin errors++; $display("FAIL drain_inflight got=%0d exp=0", inflight); end
        tick();
    endtask

    task automatic test_reset();
        clear_id();
        drive_pipe(1'b0);
        rst_n = 1'b0;
        #3;
        checks += 8;
        if (busy !== '0) begin errors++; $display("FAIL rst_busy got=%h exp=0", busy); end
        if (inflight !== '0) begin errors++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
        if (fp_stall !== 1'b0) begin errors++; $display("FAIL rst_fp_stall got=%b exp=0", fp_stall); end
        if (fp_issue !== 1'b0) begin errors++; $display("FAIL rst_fp_issue got=%b exp=0", fp_issue); end
        if (div_start !== 1'b0) begin errors++; $display("FAIL rst_div_start got=%b exp=0", div_start); end
        if (div_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_div_wb_valid got=%b exp=0", div_wb_valid); end
        if (div_wb_addr !== '0) begin errors++; $display("FAIL rst_div_wb_addr got=%0d exp=0", div_wb_addr); end
        if (divStateDbg !== 2'd0) begin errors++; $display("FAIL rst_div_state got=%0d exp=0", divStateDbg); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_latency();
        int t = cyc;
        present_op(1'b1, 5, 1'b0, 0);
        @(negedge clk);
        checks += 2;
        if (div_start !== 1'b1) begin errors++; $display("FAIL lat_div_start got=%b exp=1", div_start); end
        if (fp_issue !== 1'b1) begin errors++; $display("FAIL lat_fp_issue got=%b exp=1", fp_issue); end
        tick();
        clear_id();
        for (int k = 1; k <= DIV_LAT + 1; k++) begin
            if (k == DIV_LAT + 1) present_op(1'b1, 6, 1'b0, 0);
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (busy[5] !== 1'b1) begin errors++; $display("FAIL lat_busy5_set got=%b exp=1", busy[5]); end
            end
            if (k == DIV_LAT + 1) begin
                checks += 3;
                if (div_wb_valid !== 1'b1) begin errors++; $display("FAIL lat_wb_valid cyc=t+%0d got=%b exp=1", cyc - t, div_wb_valid); end
                if (div_wb_addr !== SCALE'(5)) begin errors++; $display("FAIL lat_wb_addr got=%0d exp=5", div_wb_addr); end
                if (fp_stall !== 1'b1) begin errors++; $display("FAIL lat_next_div_stall got=%b exp=1", fp_stall); end
            end else begin
                checks++;
                if (div_wb_valid !== 1'b0) begin errors++; $display("FAIL lat_early_wb cyc=t+%0d got=%b exp=0", cyc - t, div_wb_valid); end
            end
            tick();
        end
        @(negedge clk);
        checks += 2;
        if (busy[5] !== 1'b0) begin errors++; $display("FAIL lat_busy5_clr got=%b exp=0", busy[5]); end
        if (fp_issue !== 1'b1) begin errors++; $display("FAIL lat_next_div_issue got=%b exp=1", fp_issue); end
        tick();
        drain();
    endtask

    task automatic test_raw();
        int t = cyc;
        int got = -1;
        present_op(1'b0, 1, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (fp_issue !== 1'b1) begin errors++; $display("FAIL raw_producer_issue got=%b exp=1", fp_issue); end
        tick();
        present_op(1'b0, 2, 1'b1, 1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (fp_stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc=t+%0d got=%b exp=1", k, fp_stall); end
            tick();
        end
        for (int k = 0; k < 4 && got < 0; k++) begin
            drive_pipe(k == 0);
            @(negedge clk);
            if (fp_issue) got = cyc - t;
            tick();
        end
        clear_id();
        drive_pipe(1'b0);
        checks++;
        if (got !== 3 + (1 - FWD)) begin errors++; $display("FAIL raw_issue_cycle got=t+%0d exp=t+%0d", got, 3 + (1 - FWD)); end
        drain();
    endtask

    task automatic test_conflict();
        int t = cyc;
        present_op(1'b1, 7, 1'b0, 0);
        tick();
        present_op(1'b0, 8, 1'b0, 0);
        tick();
        present_op(1'b0, 9, 1'b0, 0);
        tick();
        clear_id();
        while (cyc < t + DIV_LAT + 1) tick();
        for (int k = 0; k < 2; k++) begin
            drive_pipe(1'b1);
            @(negedge clk);
            checks++;
            if (div_wb_valid !== 1'b0) begin errors++; $display("FAIL conf_blocked k=%0d got=%b exp=0", k, div_wb_valid); end
            tick();
        end
        drive_pipe(1'b0);
        @(negedge clk);
        checks += 2;
        if (div_wb_valid !== 1'b1) begin errors++; $display("FAIL conf_granted got=%b exp=1", div_wb_valid); end
        if (div_wb_addr !== SCALE'(7)) begin errors++; $display("FAIL conf_addr got=%0d exp=7", div_wb_addr); end
        tick();
        @(negedge clk);
        checks++;
        if (busy[9:7] !== 3'b000) begin errors++; $display("FAIL conf_busy got=%b exp=000", busy[9:7]); end
        drain();
    endtask

    task automatic test_struct();
        int t;
        int got = -1;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            present_op(1'b0, 10 + i, 1'b0, 0);
            @(negedge clk);
            checks++;
            if (fp_issue !== 1'b1) begin errors++; $display("FAIL st_fill_issue i=%0d got=%b exp=1", i, fp_issue); end
            tick();
        end
        present_op(1'b0, 14, 1'b0, 0);
        @(negedge clk);
        checks += 2;
        if (fp_stall !== 1'b1) begin errors++; $display("FAIL st_full_stall got=%b exp=1", fp_stall); end
        if (inflight !== IFW'(MAX_INFLIGHT)) begin errors++; $display("FAIL st_inflight got=%0d exp=%0d", inflight, MAX_INFLIGHT); end
        tick();
        drive_pipe(1'b1);
        @(negedge clk);
        checks++;
        if (fp_issue !== 1'(FWD)) begin errors++; $display("FAIL st_full_with_done got=%b exp=%0d", fp_issue, FWD); end
        tick();
        drain();
        t = cyc;
        present_op(1'b1, 15, 1'b0, 0);
        tick();
        present_op(1'b1, 16, 1'b0, 0);
        for (int k = 0; k < DIV_LAT + 6 && got < 0; k++) begin
            @(negedge clk);
            if (fp_issue) got = cyc - t;
            tick();
        end
        checks++;
        if (got !== DIV_LAT + 2) begin errors++; $display("FAIL st_second_div got=t+%0d exp=t+%0d", got, DIV_LAT + 2); end
        drain();
    endtask

    task automatic test_flush();
        present_op(1'b0, 20, 1'b0, 0);
        flush = 1'b1;
        @(negedge clk);
        checks += 2;
        if (fp_issue !== 1'b0) begin errors++; $display("FAIL flush_issue got=%b exp=0", fp_issue); end
        if (fp_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", fp_stall); end
        tick();
        flush = 1'b0;
        ex_stall = 1'b1;
        @(negedge clk);
        checks += 3;
        if (busy !== '0) begin errors++; $display("FAIL flush_busy got=%h exp=0", busy); end
        if (fp_issue !== 1'b0) begin errors++; $display("FAIL exstall_issue got=%b exp=0", fp_issue); end
        if (fp_stall !== 1'b0) begin errors++; $display("FAIL exstall_stall got=%b exp=0", fp_stall); end
        tick();
        clear_id();
        @(negedge clk);
        checks += 2;
        if (busy !== '0) begin errors++; $display("FAIL exstall_busy got=%h exp=0", busy); end
        if (inflight !== '0) begin errors++; $display("FAIL exstall_inflight got=%0d exp=0", inflight); end
        tick();
    endtask

    task automatic test_reset_mid_div();
        present_op(1'b1, 3, 1'b0, 0);
        tick();
        clear_id();
        for (int k = 0; k < 6; k++) tick();
        checks += 2;
        if (divStateDbg === 2'd0) begin errors++; $display("FAIL mid_div_running got=%0d exp=nonzero", divStateDbg); end
        if (busy[3] !== 1'b1) begin errors++; $display("FAIL mid_div_busy3 got=%b exp=1", busy[3]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== '0) begin errors++; $display("FAIL mid_rst_busy got=%h exp=0", busy); end
        if (divStateDbg !== 2'd0) begin errors++; $display("FAIL mid_rst_state got=%0d exp=0", divStateDbg); end
        if (div_wb_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wb got=%b exp=0", div_wb_valid); end
        if (div_wb_addr !== '0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", div_wb_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < DIV_LAT + 4; k++) begin
            @(negedge clk);
            checks++;
            if (div_wb_valid !== 1'b0) begin errors++; $display("FAIL mid_abandoned k=%0d got=%b exp=0", k, div_wb_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 9) < 7);
            id_float = ($urandom_range(0, 9) < 8);
            id_div   = ($urandom_range(0, 9) == 0);
            id_fwe   = id_div | ($urandom_range(0, 3) != 0);
            id_fdes  = SCALE'($urandom_range(0, 7));
            id_fsrc1 = SCALE'($urandom_range(0, 7));
            id_fsrc2 = SCALE'($urandom_range(0, 7));
            id_fuse1 = 1'($urandom_range(0, 1));
            id_fuse2 = 1'($urandom_range(0, 1));
            ex_stall = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            drive_pipe(exp_q.size() > 0 && $urandom_range(0, 2) == 0);
            @(negedge clk);
            predict();
            checks += 6;
            if (fp_stall !== expStall) begin errors++; $display("FAIL rnd_fp_stall cyc=%0d got=%b exp=%b", cyc, fp_stall, expStall); end
            if (fp_issue !== expIssue) begin errors++; $display("FAIL rnd_fp_issue cyc=%0d got=%b exp=%b", cyc, fp_issue, expIssue); end
            if (div_start !== expStart) begin errors++; $display("FAIL rnd_div_start cyc=%0d got=%b exp=%b", cyc, div_start, expStart); end
            if (div_wb_valid !== expDivWb) begin errors++; $display("FAIL rnd_div_wb_valid cyc=%0d got=%b exp=%b", cyc, div_wb_valid, expDivWb); end
            if (busy !== mBusy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy, mBusy); end
            if (inflight !== IFW'(exp_q.size())) begin errors++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, exp_q.size()); end
            if (expDivWb) begin
                checks++;
                if (div_wb_addr !== mDivAddr) begin errors++; $display("FAIL rnd_div_wb_addr cyc=%0d got=%0d exp=%0d", cyc, div_wb_addr, mDivAddr); end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_div_latency();
        test_raw();
        test_conflict();
        test_struct();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
